// File: rtl/pcam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcam_pkg
// Brief    : Shared types and default geometry for the PCAM coordinate tracker
// Revision : 1.0 - initial release
// ============================================================================
package pcam_pkg;

    // Frame-lock FSM states
    typedef enum logic [1:0] {
        S_UNLOCK = 2'd0,
        S_VBLANK = 2'd1,
        S_LINE   = 2'd2,
        S_HBLANK = 2'd3
    } state_t;

    // Default geometry (1080p, 24-bit RGB)
    localparam int C_DEF_H_ACTIVE = 1920;
    localparam int C_DEF_V_ACTIVE = 1080;
    localparam int C_DEF_DATA_W   = 24;
    localparam int C_DEF_FCNT_W   = 16;

endpackage
`default_nettype wire

// File: rtl/pcam_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : pcam_sync_edge
// Brief    : Normalises vsync polarity and detects vsync/VDE edges against the
//            previous sampled value
// Revision : 1.0 - initial release
// ============================================================================
module pcam_sync_edge #(
    parameter int VSYNC_POL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic vid_vsync,
    input  logic vid_active_video,
    output logic vs_rise,
    output logic vde_rise,
    output logic vde_fall
);

    logic w_vs;
    logic r_vs_d;
    logic r_vde_d;

    assign w_vs = (VSYNC_POL != 0) ? vid_vsync : ~vid_vsync;

    // Remember last sampled vsync/VDE for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vs_d  <= 1'b0;
            r_vde_d <= 1'b0;
        end else begin
            r_vs_d  <= w_vs;
            r_vde_d <= vid_active_video;
        end
    end

    assign vs_rise  = w_vs & ~r_vs_d;
    assign vde_rise = vid_active_video & ~r_vde_d;
    assign vde_fall = ~vid_active_video & r_vde_d;

endmodule
`default_nettype wire

// File: rtl/pcam_coord_tracker.sv
`default_nettype none
// ============================================================================
// Module   : pcam_coord_tracker
// Brief    : Converts VDE/VSYNC/pixel video into registered x/y coordinates,
//            frame/line markers, ROI flag and sticky timing-error status
// Revision : 1.0 - initial release
// ============================================================================
module pcam_coord_tracker
    import pcam_pkg::*;
#(
    parameter  int H_ACTIVE  = C_DEF_H_ACTIVE,
    parameter  int V_ACTIVE  = C_DEF_V_ACTIVE,
    parameter  int DATA_W    = C_DEF_DATA_W,
    parameter  int VSYNC_POL = 1,
    parameter  int FCNT_W    = C_DEF_FCNT_W,
    localparam int XW        = $clog2(H_ACTIVE),
    localparam int YW        = $clog2(V_ACTIVE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_active_video,
    input  logic              vid_vsync,
    input  logic [DATA_W-1:0] vid_data,
    input  logic [XW-1:0]     roi_x0,
    input  logic [XW-1:0]     roi_x1,
    input  logic [YW-1:0]     roi_y0,
    input  logic [YW-1:0]     roi_y1,
    input  logic              err_clr,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              in_roi,
    output logic              locked,
    output logic              err_line,
    output logic              err_frame,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam logic [XW-1:0] C_X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] C_Y_LAST = YW'(V_ACTIVE - 1);

    // Edge detection
    logic w_vs_rise;
    logic w_vde_rise;
    logic w_vde_fall;

    pcam_sync_edge #(
        .VSYNC_POL (VSYNC_POL)
    ) u_sync_edge (
        .clk              (clk),
        .reset            (reset),
        .vid_vsync        (vid_vsync),
        .vid_active_video (vid_active_video),
        .vs_rise          (w_vs_rise),
        .vde_rise         (w_vde_rise),
        .vde_fall         (w_vde_fall)
    );

    // State and counters. x/y saturate at the last active index; the *_over
    // flags remember that the line/frame has run past its geometry.
    state_t          r_state;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic            r_x_over;
    logic            r_y_over;
    logic            r_first_line;
    logic            r_locked;
    logic [XW-1:0]   r_roi_x0;
    logic [XW-1:0]   r_roi_x1;
    logic [YW-1:0]   r_roi_y0;
    logic [YW-1:0]   r_roi_y1;

    logic            w_line_start;
    logic            w_line_cont;
    logic            w_line_end;
    logic [XW-1:0]   w_x_nxt;
    logic [YW-1:0]   w_y_nxt;
    logic            w_x_over_nxt;
    logic            w_y_over_nxt;
    logic            w_frame_full;
    logic            w_valid;
    logic            w_eol;
    logic            w_set_line;
    logic            w_set_frame;
    logic            w_in_roi;

    // Classify the sampled cycle and compute next coordinates
    always_comb begin
        w_line_start = 1'b0;
        w_line_cont  = 1'b0;
        w_line_end   = 1'b0;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_x_over_nxt = r_x_over;
        w_y_over_nxt = r_y_over;
        if (w_vs_rise) begin
            w_y_nxt      = '0;
            w_y_over_nxt = 1'b0;
            w_x_over_nxt = 1'b0;
        end else if ((r_state == S_VBLANK || r_state == S_HBLANK) && w_vde_rise) begin
            w_line_start = 1'b1;
            w_x_nxt      = '0;
            w_x_over_nxt = 1'b0;
            if (r_first_line) begin
                w_y_nxt = '0;
            end else if (r_y_over || r_y == C_Y_LAST) begin
                w_y_over_nxt = 1'b1;
            end else begin
                w_y_nxt = r_y + YW'(1);
            end
        end else if (r_state == S_LINE && vid_active_video) begin
            w_line_cont = 1'b1;
            if (r_x_over || r_x == C_X_LAST) begin
                w_x_over_nxt = 1'b1;
            end else begin
                w_x_nxt = r_x + XW'(1);
            end
        end else if (r_state == S_LINE && w_vde_fall) begin
            w_line_end = 1'b1;
        end
    end

    // A frame is complete only when exactly V_ACTIVE lines were started
    assign w_frame_full = !r_first_line && !r_y_over && (r_y == C_Y_LAST);

    assign w_valid = (w_line_start || w_line_cont) && !w_x_over_nxt && !w_y_over_nxt;
    assign w_eol   = w_valid && (w_x_nxt == C_X_LAST);

    assign w_set_line  = (w_line_cont && w_x_over_nxt) ||
                         (w_line_end && !r_x_over && (r_x != C_X_LAST));
    assign w_set_frame = (w_vs_rise && ((r_state == S_LINE) || (r_locked && !w_frame_full))) ||
                         (w_line_start && w_y_over_nxt);

    assign w_in_roi = w_valid &&
                      (w_x_nxt >= r_roi_x0) && (w_x_nxt <= r_roi_x1) &&
                      (w_y_nxt >= r_roi_y0) && (w_y_nxt <= r_roi_y1);

    // Frame-lock FSM, counters and registered output stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_UNLOCK;
            r_x          <= '0;
            r_y          <= '0;
            r_x_over     <= 1'b0;
            r_y_over     <= 1'b0;
            r_first_line <= 1'b0;
            r_locked     <= 1'b0;
            r_roi_x0     <= '0;
            r_roi_x1     <= '0;
            r_roi_y0     <= '0;
            r_roi_y1     <= '0;
            pix_valid    <= 1'b0;
            pix_data     <= '0;
            sof          <= 1'b0;
            eol          <= 1'b0;
            eof          <= 1'b0;
            in_roi       <= 1'b0;
            err_line     <= 1'b0;
            err_frame    <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            if (w_vs_rise) begin
                r_state      <= S_VBLANK;
                r_first_line <= 1'b1;
                r_locked     <= 1'b1;
                frame_cnt    <= frame_cnt + FCNT_W'(1);
                r_roi_x0     <= roi_x0;
                r_roi_x1     <= roi_x1;
                r_roi_y0     <= roi_y0;
                r_roi_y1     <= roi_y1;
            end else if (w_line_start) begin
                r_state      <= S_LINE;
                r_first_line <= 1'b0;
            end else if (w_line_end) begin
                r_state      <= S_HBLANK;
            end

            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_x_over  <= w_x_over_nxt;
            r_y_over  <= w_y_over_nxt;

            pix_valid <= w_valid;
            pix_data  <= vid_data;
            sof       <= w_valid && (w_x_nxt == '0) && (w_y_nxt == '0);
            eol       <= w_eol;
            eof       <= w_eol && (w_y_nxt == C_Y_LAST);
            in_roi    <= w_in_roi;

            // Setting an error takes priority over a simultaneous clear
            if (w_set_line)   err_line <= 1'b1;
            else if (err_clr) err_line <= 1'b0;

            if (w_set_frame)  err_frame <= 1'b1;
            else if (err_clr) err_frame <= 1'b0;
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign locked = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_pcam_coord_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcam_coord_tracker
// Brief    : Self-checking bench for pcam_coord_tracker (8x4 geometry), one
//            instance per vsync polarity, both compared to a stream model
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcam_coord_tracker;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int DW = 24;
    localparam int FW = 16;
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          vde = 1'b0;
    logic          vs = 1'b0;
    logic [DW-1:0] data = '0;
    logic          clr = 1'b0;
    logic [XW-1:0] rx0 = '0, rx1 = '0;
    logic [YW-1:0] ry0 = '0, ry1 = '0;
    logic          vs_n;

    logic          a_v, a_sof, a_eol, a_eof, a_roi, a_lk, a_el, a_ef;
    logic [DW-1:0] a_d;
    logic [XW-1:0] a_x;
    logic [YW-1:0] a_y;
    logic [FW-1:0] a_fc;
    logic          b_v, b_sof, b_eol, b_eof, b_roi, b_lk, b_el, b_ef;
    logic [DW-1:0] b_d;
    logic [XW-1:0] b_x;
    logic [YW-1:0] b_y;
    logic [FW-1:0] b_fc;

    always #5 clk = ~clk;
    assign vs_n = ~vs;

    pcam_coord_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .VSYNC_POL(1), .FCNT_W(FW)) u_dut_hi (
        .clk(clk), .reset(reset), .vid_active_video(vde), .vid_vsync(vs), .vid_data(data),
        .roi_x0(rx0), .roi_x1(rx1), .roi_y0(ry0), .roi_y1(ry1), .err_clr(clr),
        .pix_valid(a_v), .pix_data(a_d), .x(a_x), .y(a_y), .sof(a_sof), .eol(a_eol), .eof(a_eof),
        .in_roi(a_roi), .locked(a_lk), .err_line(a_el), .err_frame(a_ef), .frame_cnt(a_fc));

    pcam_coord_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .VSYNC_POL(0), .FCNT_W(FW)) u_dut_lo (
        .clk(clk), .reset(reset), .vid_active_video(vde), .vid_vsync(vs_n), .vid_data(data),
        .roi_x0(rx0), .roi_x1(rx1), .roi_y0(ry0), .roi_y1(ry1), .err_clr(clr),
        .pix_valid(b_v), .pix_data(b_d), .x(b_x), .y(b_y), .sof(b_sof), .eol(b_eol), .eof(b_eof),
        .in_roi(b_roi), .locked(b_lk), .err_line(b_el), .err_frame(b_ef), .frame_cnt(b_fc));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural stream model ----------------
    typedef struct {
        bit            valid;
        logic [DW-1:0] data;
        int            x, y;
        bit            sof, eol, eof, roi, locked, el, ef;
        int            fc;
    } exp_t;

    exp_t q[$];
    bit   m_pvs, m_pvde, m_locked, m_inline, m_el, m_ef;
    int   m_lines, m_pix, m_fc;
    int   m_x0, m_x1, m_y0, m_y1;
    bit   rnd_clr = 1'b0;
    int   n_sof = 0, n_eof = 0, n_roi = 0;

    task automatic model_reset();
        m_pvs = 0; m_pvde = 0; m_locked = 0; m_inline = 0; m_el = 0; m_ef = 0;
        m_lines = 0; m_pix = 0; m_fc = 0; m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
    endtask

    // One sampled input cycle -> expected output after the next clock edge
    task automatic model_step();
        exp_t e;
        bit fs, rise, setl, setf;
        fs = vs && !m_pvs;
        rise = vde && !m_pvde;
        setl = 0; setf = 0;
        e.valid = 0; e.x = 0; e.y = 0;
        if (fs) begin
            if (m_inline) setf = 1;
            if (m_locked && m_lines != V) setf = 1;
            m_locked = 1; m_lines = 0; m_inline = 0;
            m_fc = (m_fc + 1) % (1 << FW);
            m_x0 = rx0; m_x1 = rx1; m_y0 = ry0; m_y1 = ry1;
        end else if (m_locked) begin
            if (!m_inline && rise) begin
                m_inline = 1; m_lines++; m_pix = 1;
                if (m_lines > V) setf = 1;
                else begin e.valid = 1; e.x = 0; e.y = m_lines - 1; end
            end else if (m_inline && vde) begin
                m_pix++;
                if (m_pix > H) setl = 1;
                else if (m_lines <= V) begin e.valid = 1; e.x = m_pix - 1; e.y = m_lines - 1; end
            end else if (m_inline && !vde) begin
                if (m_pix < H) setl = 1;
                m_inline = 0;
            end
        end
        m_el = setl ? 1'b1 : (clr ? 1'b0 : m_el);
        m_ef = setf ? 1'b1 : (clr ? 1'b0 : m_ef);
        e.data = data;
        e.sof = e.valid && e.x == 0 && e.y == 0;
        e.eol = e.valid && e.x == H - 1;
        e.eof = e.eol && e.y == V - 1;
        e.roi = e.valid && e.x >= m_x0 && e.x <= m_x1 && e.y >= m_y0 && e.y <= m_y1;
        e.locked = m_locked; e.el = m_el; e.ef = m_ef; e.fc = m_fc;
        m_pvs = vs; m_pvde = vde;
        q.push_back(e);
    endtask

    task automatic cmp_dut(input string t, input exp_t e, input logic v, input logic [DW-1:0] d,
                           input logic [XW-1:0] xx, input logic [YW-1:0] yy, input logic so,
                           input logic eo, input logic ef_, input logic ro, input logic lk,
                           input logic el, input logic efr, input logic [FW-1:0] fc);
        chk({t, ".pix_valid"}, int'(v), int'(e.valid));
        chk({t, ".sof"}, int'(so), int'(e.sof));
        chk({t, ".eol"}, int'(eo), int'(e.eol));
        chk({t, ".eof"}, int'(ef_), int'(e.eof));
        chk({t, ".in_roi"}, int'(ro), int'(e.roi));
        chk({t, ".locked"}, int'(lk), int'(e.locked));
        chk({t, ".err_line"}, int'(el), int'(e.el));
        chk({t, ".err_frame"}, int'(efr), int'(e.ef));
        chk({t, ".frame_cnt"}, int'(fc), e.fc);
        if (e.valid) begin
            chk({t, ".x"}, int'(xx), e.x);
            chk({t, ".y"}, int'(yy), e.y);
            chk({t, ".pix_data"}, int'(d), int'(e.data));
        end
    endtask

    // Compare process: both polarity builds against the model every cycle
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp_dut("hi", e, a_v, a_d, a_x, a_y, a_sof, a_eol, a_eof, a_roi, a_lk, a_el, a_ef, a_fc);
            cmp_dut("lo", e, b_v, b_d, b_x, b_y, b_sof, b_eol, b_eof, b_roi, b_lk, b_el, b_ef, b_fc);
            if (a_sof) n_sof++;
            if (a_eof) n_eof++;
            if (a_roi) n_roi++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit v, input bit s, input bit c = 1'b0);
        @(negedge clk);
        vde = v;
        vs = s;
        clr = c | (rnd_clr && ($urandom % 16 == 0));
        data = DW'($urandom);
        model_step();
    endtask

    // Observe outputs of the cycle just driven
    task automatic probe();
        @(posedge clk);
        #2;
    endtask

    task automatic vpulse();
        cyc(0, 1); cyc(0, 1);
        repeat (2 + $urandom % 2) cyc(0, 0);
    endtask

    task automatic body(input int nl, input int bad_l, input int bad_len,
                        input int ab_l, input int ab_p, input int chg_l);
        int len;
        for (int l = 0; l < nl; l++) begin
            len = (l == bad_l) ? bad_len : H;
            if (l == chg_l) begin rx0 = '0; rx1 = XW'(H - 1); end
            for (int p = 0; p < len; p++) begin
                if (l == ab_l && p == ab_p) begin
                    cyc(1, 1);
                    probe();
                    chk("abort_err_frame", int'(a_ef), 1);
                    chk("abort_pix_valid", int'(a_v), 0);
                    cyc(1, 0);
                    cyc(0, 0);
                    return;
                end
                cyc(1, 0);
            end
            repeat (1 + $urandom % 3) cyc(0, 0);
        end
    endtask

    task automatic frame(input int nl, input int bad_l, input int bad_len,
                         input int ab_l, input int ab_p, input int chg_l);
        vpulse();
        body(nl, bad_l, bad_len, ab_l, ab_p, chg_l);
    endtask

    task automatic do_reset();
        vde = 0; vs = 0; clr = 0;
        reset = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();
        #1;
        chk("reset_frame_cnt", int'(a_fc), 0);
        chk("reset_locked", int'(a_lk), 0);

        // Clean frames
        n_sof = 0; n_eof = 0;
        repeat (3) frame(V, -1, 0, -1, -1, -1);
        cyc(0, 0); cyc(0, 0);
        probe();
        chk("clean_frame_cnt", int'(a_fc), 3);
        chk("clean_sof_count", n_sof, 3);
        chk("clean_eof_count", n_eof, 3);
        chk("clean_err_line", int'(a_el), 0);
        chk("clean_err_frame", int'(a_ef), 0);

        // VDE before first vsync is ignored
        do_reset();
        for (int p = 0; p < H; p++) begin
            cyc(1, 0);
            if (p == 3) begin
                probe();
                chk("prelock_valid", int'(a_v), 0);
                chk("prelock_locked", int'(a_lk), 0);
            end
        end
        cyc(0, 0);
        cyc(0, 1);
        probe();
        chk("lock_after_vsync", int'(a_lk), 1);
        cyc(0, 0); cyc(0, 0);
        cyc(1, 0);
        probe();
        chk("first_line_y", int'(a_y), 0);
        chk("first_line_sof", int'(a_sof), 1);
        for (int p = 1; p < H; p++) cyc(1, 0);
        cyc(0, 0); cyc(0, 0);
        body(V - 1, -1, 0, -1, -1, -1);

        // Overlong line (10 pixels) then clear
        vpulse();
        body(1, -1, 0, -1, -1, -1);
        for (int p = 0; p < H + 2; p++) begin
            cyc(1, 0);
            if (p >= H - 1) begin
                probe();
                chk("long_x", int'(a_x), H - 1);
                chk("long_valid", int'(a_v), (p == H - 1) ? 1 : 0);
                chk("long_err_line", int'(a_el), (p == H - 1) ? 0 : 1);
            end
        end
        cyc(0, 0); cyc(0, 0);
        body(2, -1, 0, -1, -1, -1);
        cyc(0, 0, 1);
        probe();
        chk("clr_err_line", int'(a_el), 0);

        // Short frame, then abort mid-line
        frame(3, -1, 0, -1, -1, -1);
        chk("short_before_vs", int'(a_ef), 0);
        cyc(0, 1);
        probe();
        chk("short_err_frame", int'(a_ef), 1);
        cyc(0, 1);
        cyc(0, 0, 1);
        probe();
        chk("clr_err_frame", int'(a_ef), 0);
        cyc(0, 0);
        body(V, -1, 0, 2, 3, -1);
        frame(V, -1, 0, -1, -1, -1);
        cyc(0, 0, 1);

        // ROI: 4 columns x 2 rows, mid-frame change deferred to next frame
        rx0 = 3'd2; rx1 = 3'd5; ry0 = 2'd1; ry1 = 2'd2;
        n_roi = 0;
        frame(V, -1, 0, -1, -1, -1);
        chk("roi_count", n_roi, 8);
        n_roi = 0;
        frame(V, -1, 0, -1, -1, 1);
        chk("roi_midframe_count", n_roi, 8);
        n_roi = 0;
        frame(V, -1, 0, -1, -1, -1);
        chk("roi_next_frame_count", n_roi, 16);

        // Randomized frames with malformed timing and random clears
        rnd_clr = 1'b1;
        for (int f = 0; f < 30; f++) begin
            int nl, bl, blen, al, ap, cl;
            rx0 = XW'($urandom % H); rx1 = XW'($urandom % H);
            ry0 = YW'($urandom % V); ry1 = YW'($urandom % V);
            nl   = ($urandom % 4 == 0) ? 3 + int'($urandom % 3) : V;
            bl   = ($urandom % 3 == 0) ? int'($urandom % nl) : -1;
            blen = 5 + int'($urandom % 7);
            al   = ($urandom % 6 == 0) ? int'($urandom % nl) : -1;
            ap   = int'($urandom % H);
            cl   = ($urandom % 4 == 0) ? int'($urandom % nl) : -1;
            frame(nl, bl, blen, al, ap, cl);
        end
        rnd_clr = 1'b0;

        // Asynchronous reset mid-line
        vpulse();
        cyc(1, 0); cyc(1, 0); cyc(1, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        q.delete();
        #1;
        chk("async_rst_valid", int'(a_v), 0);
        chk("async_rst_x", int'(a_x), 0);
        chk("async_rst_locked", int'(a_lk), 0);
        chk("async_rst_frame_cnt", int'(a_fc), 0);
        chk("async_rst_lo_locked", int'(b_lk), 0);
        vde = 0; vs = 0; clr = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) frame(V, -1, 0, -1, -1, -1);
        cyc(0, 0); cyc(0, 0);
        probe();
        chk("relock_frame_cnt", int'(a_fc), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
